// File: rtl/hpdmc_obuft_seq.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// hpdmc_obuft_seq
//
// Sequenced tristate output driver bank for the HPDMC DDR write data path.
// A write burst is accepted from IDLE. One data beat is fetched per cycle into
// registered pad outputs. The bus stays driven with the last beat for a
// postamble. It is then released (high-Z) for a turnaround period before the
// bank returns to IDLE and can take the next request.
//
// Parameters:
//   WIDTH      total data bits driven (multiple of LANES)
//   LANES      byte lanes; lane l = bits [l*(WIDTH/LANES) +: WIDTH/LANES]
//   POSTAMBLE  cycles (0..15) the last beat is held on the bus after a burst
//   TURNAROUND cycles (0..15) the bus is high-Z and busy before IDLE
//
// Ports:
//   sys_clk   in   system clock, rising edge
//   sys_rst   in   asynchronous active-high reset
//   drv_req   in   burst request, held until drv_ack
//   drv_len   in   burst length minus one, sampled with drv_ack
//   drv_ack   out  request accepted (combinational, IDLE only)
//   drv_busy  out  registered, high whenever not IDLE
//   data_rd   out  beat strobe; data_in/mask_in consumed at the ending edge
//   data_in   in   beat data
//   mask_in   in   per-lane mask, 1 = leave lane undriven for that beat
//   pad_o     out  registered data to OBUFT I
//   pad_t     out  registered tristate to OBUFT T (1 = high-Z)
//
// Build option:
//   HPDMC_OBUFT_MASK_EN  when defined, mask_in is registered with each beat
//                        and masked lanes stay high-Z for that beat (and for
//                        the postamble if it was the last beat). When not
//                        defined, mask_in is ignored and all lanes are driven.
// -----------------------------------------------------------------------------
module hpdmc_obuft_seq #(
  parameter int WIDTH      = 16,
  parameter int LANES      = 2,
  parameter int POSTAMBLE  = 1,
  parameter int TURNAROUND = 1
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  input  logic               drv_req,
  input  logic [3:0]         drv_len,
  output logic               drv_ack,
  output logic               drv_busy,
  output logic               data_rd,
  input  logic [WIDTH-1:0]   data_in,
  input  logic [LANES-1:0]   mask_in,
  output logic [WIDTH-1:0]   pad_o,
  output logic [WIDTH-1:0]   pad_t
);

  localparam int LANE_W = WIDTH / LANES;

  // Counter reload values; a zero-length phase is skipped entirely, so the
  // reload is only used when the corresponding parameter is non-zero.
  localparam logic [3:0] POST_LOAD = (POSTAMBLE > 0)  ? 4'(POSTAMBLE - 1)  : 4'd0;
  localparam logic [3:0] TURN_LOAD = (TURNAROUND > 0) ? 4'(TURNAROUND - 1) : 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_POST  = 2'd2,
    ST_TURN  = 2'd3
  } state_t;

  state_t             state_reg;
  logic [3:0]         cnt_reg;
  logic               busy_reg;
  logic [WIDTH-1:0]   pad_o_reg;
  logic [WIDTH-1:0]   pad_t_reg;

  // Tristate pattern for the beat being fetched this cycle.
  logic [WIDTH-1:0]   beat_t;

  genvar gi;
`ifdef HPDMC_OBUFT_MASK_EN
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane_mask
      assign beat_t[gi*LANE_W +: LANE_W] = {LANE_W{mask_in[gi]}};
    end
  endgenerate
`else
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane_drive
      assign beat_t[gi*LANE_W +: LANE_W] = '0;
    end
  endgenerate
  // Mask is a don't-care in this build.
  logic unused_mask;
  assign unused_mask = ^mask_in;
`endif

  logic accept;
  logic fetch;

  assign accept = drv_req && (state_reg == ST_IDLE);
  // In DRIVE the beat that ends on cnt==0 is already on the pads, so no fetch.
  assign fetch  = accept || ((state_reg == ST_DRIVE) && (cnt_reg != 4'd0));

  // Reset already forces IDLE asynchronously; the explicit gating keeps the
  // strobes low even while a requester holds drv_req through reset.
  assign drv_ack  = accept && !sys_rst;
  assign data_rd  = fetch && !sys_rst;
  assign drv_busy = busy_reg;
  assign pad_o    = pad_o_reg;
  assign pad_t    = pad_t_reg;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= 4'd0;
      busy_reg  <= 1'b0;
      pad_o_reg <= '0;
      pad_t_reg <= '1;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (drv_req) begin
            pad_o_reg <= data_in;
            pad_t_reg <= beat_t;
            cnt_reg   <= drv_len;
            busy_reg  <= 1'b1;
            state_reg <= ST_DRIVE;
          end
        end

        ST_DRIVE: begin
          if (cnt_reg != 4'd0) begin
            pad_o_reg <= data_in;
            pad_t_reg <= beat_t;
            cnt_reg   <= cnt_reg - 4'd1;
          end else if (POSTAMBLE > 0) begin
            // Last beat stays on the pads with its own lane pattern.
            cnt_reg   <= POST_LOAD;
            state_reg <= ST_POST;
          end else if (TURNAROUND > 0) begin
            pad_t_reg <= '1;
            cnt_reg   <= TURN_LOAD;
            state_reg <= ST_TURN;
          end else begin
            pad_t_reg <= '1;
            busy_reg  <= 1'b0;
            state_reg <= ST_IDLE;
          end
        end

        ST_POST: begin
          if (cnt_reg != 4'd0) begin
            cnt_reg <= cnt_reg - 4'd1;
          end else if (TURNAROUND > 0) begin
            pad_t_reg <= '1;
            cnt_reg   <= TURN_LOAD;
            state_reg <= ST_TURN;
          end else begin
            pad_t_reg <= '1;
            busy_reg  <= 1'b0;
            state_reg <= ST_IDLE;
          end
        end

        ST_TURN: begin
          if (cnt_reg != 4'd0) begin
            cnt_reg <= cnt_reg - 4'd1;
          end else begin
            busy_reg  <= 1'b0;
            state_reg <= ST_IDLE;
          end
        end

        default: begin
          pad_t_reg <= '1;
          cnt_reg   <= 4'd0;
          busy_reg  <= 1'b0;
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hpdmc_obuft_seq.sv
`timescale 1ns/1ps
// Testbench for hpdmc_obuft_seq. DUT a uses the default timing (postamble 1,
// turnaround 1); DUT b has both gaps set to zero. Expected pad behaviour comes
// from a per-burst timeline: cycle k after accept is a data, postamble,
// turnaround or idle cycle purely by arithmetic on len, POSTAMBLE, TURNAROUND.
module tb_hpdmc_obuft_seq;

  localparam int W   = 16;
  localparam int L   = 2;
  localparam int P_A = 1;
  localparam int T_A = 1;
  localparam int P_B = 0;
  localparam int T_B = 0;

  typedef struct packed {
    logic        ack;
    logic        rd;
    logic        busy;
    logic [15:0] o;
    logic [15:0] t;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          req_a, ack_a, busy_a, rd_a;
  logic [3:0]    len_a;
  logic [W-1:0]  data_a, o_a, t_a;
  logic [L-1:0]  mask_a;
  logic          req_b, ack_b, busy_b, rd_b;
  logic [3:0]    len_b;
  logic [W-1:0]  data_b, o_b, t_b;
  logic [L-1:0]  mask_b;

  int checks = 0;
  int errors = 0;

  logic [15:0] beat_q [16];
  logic [1:0]  mask_q [16];
  logic [15:0] last_a = '0;
  logic [15:0] last_b = '0;

  hpdmc_obuft_seq #(.WIDTH(W), .LANES(L), .POSTAMBLE(P_A), .TURNAROUND(T_A)) dut_a (
    .sys_clk(clk), .sys_rst(rst), .drv_req(req_a), .drv_len(len_a),
    .drv_ack(ack_a), .drv_busy(busy_a), .data_rd(rd_a), .data_in(data_a),
    .mask_in(mask_a), .pad_o(o_a), .pad_t(t_a)
  );

  hpdmc_obuft_seq #(.WIDTH(W), .LANES(L), .POSTAMBLE(P_B), .TURNAROUND(T_B)) dut_b (
    .sys_clk(clk), .sys_rst(rst), .drv_req(req_b), .drv_len(len_b),
    .drv_ack(ack_b), .drv_busy(busy_b), .data_rd(rd_b), .data_in(data_b),
    .mask_in(mask_b), .pad_o(o_b), .pad_t(t_b)
  );

  // Tristate pattern expected for a beat with lane mask m.
  function automatic logic [15:0] lane_t(logic [1:0] m);
    logic [15:0] r;
    r = '0;
    for (int l = 0; l < 2; l++) if (m[l]) r[l*8 +: 8] = 8'hFF;
`ifndef HPDMC_OBUFT_MASK_EN
    r = '0;
`endif
    return r;
  endfunction

  // Expected outputs k cycles after the accept cycle (k = 0) of a burst.
  function automatic exp_t model(int k, int len, int p, int t, logic [15:0] prev_o);
    exp_t e;
    int nd;
    nd     = len + 1;
    e.ack  = (k == 0);
    e.rd   = (k <= len);
    e.busy = (k >= 1) && (k <= nd + p + t);
    if (k == 0) begin
      e.o = prev_o;
      e.t = '1;
    end else if (k <= nd) begin
      e.o = beat_q[k-1];
      e.t = lane_t(mask_q[k-1]);
    end else if (k <= nd + p) begin
      e.o = beat_q[len];
      e.t = lane_t(mask_q[len]);
    end else begin
      e.o = beat_q[len];
      e.t = '1;
    end
    return e;
  endfunction

  task automatic fill_random();
    for (int i = 0; i < 16; i++) begin
      beat_q[i] = 16'($urandom);
      mask_q[i] = 2'($urandom);
    end
  endtask

  task automatic test_reset();
    exp_t e;
    rst = 1'b1; req_a = 1'b1; len_a = 4'd3; data_a = 16'h1234; mask_a = '0;
    req_b = 1'b0; len_b = '0; data_b = '0; mask_b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    e = '{ack: 1'b0, rd: 1'b0, busy: 1'b0, o: 16'h0, t: 16'hFFFF};
    checks++;
    if ({ack_a, rd_a, busy_a, o_a, t_a} !== e) begin
      errors++;
      $display("FAIL reset_hold: got ack=%b rd=%b busy=%b o=%h t=%h, want 0 0 0 0000 ffff",
               ack_a, rd_a, busy_a, o_a, t_a);
    end
    req_a = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    // Start a burst, then reset it in the middle of DRIVE.
    @(posedge clk); #1 req_a = 1'b1; len_a = 4'd5; data_a = 16'hBEEF;
    @(posedge clk); #1 data_a = 16'hCAFE;
    @(posedge clk); #1 data_a = 16'hF00D;
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({ack_a, rd_a, busy_a, o_a, t_a} !== e) begin
      errors++;
      $display("FAIL reset_mid_drive: got ack=%b rd=%b busy=%b o=%h t=%h, want 0 0 0 0000 ffff",
               ack_a, rd_a, busy_a, o_a, t_a);
    end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({ack_a, rd_a, busy_a} !== 3'b110) begin
      errors++;
      $display("FAIL reset_first_ack: got ack=%b rd=%b busy=%b, want 1 1 0", ack_a, rd_a, busy_a);
    end
    #1 req_a = 1'b0;
    last_a = '0;
    $display("reset: mid-burst reset and first-request ack checked");
  endtask

  // One burst on DUT a in a given scenario; req stays high afterwards if hold.
  task automatic test_burst_a(input string name, input int len, input bit hold);
    exp_t e;
    int total;
    total = len + 1 + P_A + T_A;
    for (int k = 0; k <= total; k++) begin
      @(posedge clk); #1;
      if (k == 0) begin
        req_a = 1'b1; len_a = 4'(len);
      end else begin
        req_a = hold; len_a = 4'($urandom);
      end
      data_a = (k <= len) ? beat_q[k] : 16'($urandom);
      mask_a = (k <= len) ? mask_q[k] : 2'($urandom);
      @(negedge clk);
      e = model(k, len, P_A, T_A, last_a);
      checks++;
      if ({ack_a, rd_a, busy_a, o_a, t_a} !== e) begin
        errors++;
        $display("FAIL %s k=%0d len=%0d: got ack=%b rd=%b busy=%b o=%h t=%h, want ack=%b rd=%b busy=%b o=%h t=%h",
                 name, k, len, ack_a, rd_a, busy_a, o_a, t_a, e.ack, e.rd, e.busy, e.o, e.t);
      end
    end
    last_a = beat_q[len];
    $display("%s: burst len=%0d first=%h last=%h", name, len, beat_q[0], beat_q[len]);
  endtask

  task automatic test_single();
    beat_q[0] = 16'hA55A; mask_q[0] = 2'b00;
    test_burst_a("single", 0, 1'b0);
  endtask

  task automatic test_burst4();
    for (int i = 0; i < 4; i++) begin
      beat_q[i] = 16'(i + 1); mask_q[i] = 2'b00;
    end
    test_burst_a("burst4", 3, 1'b0);
  endtask

  task automatic test_mask();
    beat_q[0] = 16'h1111; mask_q[0] = 2'b10;
    beat_q[1] = 16'h2222; mask_q[1] = 2'b01;
    test_burst_a("mask", 1, 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 6; n++) begin
      int gap;
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        @(posedge clk); #1 req_a = 1'b0; data_a = 16'($urandom); len_a = 4'($urandom);
        @(negedge clk);
        checks++;
        if ({ack_a, rd_a, busy_a, o_a, t_a} !== {3'b000, last_a, 16'hFFFF}) begin
          errors++;
          $display("FAIL idle_gap: got ack=%b rd=%b busy=%b o=%h t=%h, want 0 0 0 %h ffff",
                   ack_a, rd_a, busy_a, o_a, t_a, last_a);
        end
      end
      fill_random();
      test_burst_a("random", $urandom_range(0, 15), 1'b0);
    end
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 3; n++) begin
      fill_random();
      test_burst_a("back_to_back", 1, n < 2);
    end
  endtask

  task automatic test_zero_gap();
    exp_t e;
    for (int n = 0; n < 4; n++) begin
      int len;
      int total;
      bit hold;
      len   = (n == 0) ? 2 : $urandom_range(0, 15);
      hold  = (n < 3);
      total = len + 1 + P_B + T_B;
      fill_random();
      for (int k = 0; k <= total; k++) begin
        @(posedge clk); #1;
        if (k == 0) begin
          req_b = 1'b1; len_b = 4'(len);
        end else begin
          req_b = hold; len_b = 4'($urandom);
        end
        data_b = (k <= len) ? beat_q[k] : 16'($urandom);
        mask_b = (k <= len) ? mask_q[k] : 2'($urandom);
        @(negedge clk);
        e = model(k, len, P_B, T_B, last_b);
        checks++;
        if ({ack_b, rd_b, busy_b, o_b, t_b} !== e) begin
          errors++;
          $display("FAIL zero_gap k=%0d len=%0d: got ack=%b rd=%b busy=%b o=%h t=%h, want ack=%b rd=%b busy=%b o=%h t=%h",
                   k, len, ack_b, rd_b, busy_b, o_b, t_b, e.ack, e.rd, e.busy, e.o, e.t);
        end
      end
      last_b = beat_q[len];
      $display("zero_gap: burst len=%0d first=%h last=%h", len, beat_q[0], beat_q[len]);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst4();
    test_mask();
    test_random();
    test_back_to_back();
    test_zero_gap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
